// File: rtl/fifo_wr_arb.sv
// Round-robin write-port arbiter and burst sequencer for the async FIFO write domain.
// Optional stall counter output enabled by defining FIFO_WARB_STALL_CNT_EN.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          w_rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  input  logic                          full,
  input  logic                          half_full,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          w_en,
  output logic [data_width-1:0]         data_in,
  output logic                          busy
`ifdef FIFO_WARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_reg, state_next;
  logic [OW-1:0]   owner_reg, owner_next;
  logic [OW-1:0]   last_grant_reg, last_grant_next;
  logic [4:0]      beat_cnt_reg, beat_cnt_next;
  logic [4:0]      burst_cap_reg, burst_cap_next;

  logic [data_width-1:0] words [NUM_REQ];
  logic [NUM_REQ-1:0]    others;
  logic [OW-1:0]         arb_idx;
  logic [OW-1:0]         cand;
  logic                  grant;
  logic                  release_now;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign words[gi]  = req_data[gi*data_width +: data_width];
      assign ack[gi]    = w_en & (owner_reg == OW'(gi));
      assign others[gi] = req[gi] & (owner_reg != OW'(gi));
    end
  endgenerate

  assign busy    = (state_reg == BURST);
  assign w_en    = busy & req[owner_reg] & ~full;
  assign data_in = w_en ? words[owner_reg] : '0;

  // Descending scan so the nearest requester after last_grant is assigned last and wins.
  always_comb begin
    arb_idx = last_grant_reg;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = OW'((int'(last_grant_reg) + k) % NUM_REQ);
      if (req[cand]) arb_idx = cand;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    burst_cap_next  = burst_cap_reg;
    grant           = 1'b0;
    release_now     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) grant = 1'b1;
      end
      BURST: begin
        if (w_en) beat_cnt_next = beat_cnt_reg + 5'd1;
        // A full stall keeps req[owner] high with w_en low, so it never releases.
        release_now = (w_en && (beat_cnt_reg + 5'd1 == burst_cap_reg)) || !req[owner_reg];
        if (release_now) begin
          if (|others) grant = 1'b1;
          else         state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (grant) begin
      state_next      = BURST;
      owner_next      = arb_idx;
      last_grant_next = arb_idx;
      beat_cnt_next   = 5'd0;
      burst_cap_next  = half_full ? 5'd1 : 5'(MAX_BURST);
    end
  end

  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_grant_reg <= OW'(NUM_REQ - 1);
      beat_cnt_reg   <= 5'd0;
      burst_cap_reg  <= 5'(MAX_BURST);
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      burst_cap_reg  <= burst_cap_next;
    end
  end

`ifdef FIFO_WARB_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      stall_cnt_reg <= 16'd0;
    end else if (busy && req[owner_reg] && full && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
